// File: rtl/schoolbook_div.sv
// Restoring shift-subtract divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Quotient bits shift into the low end of the dividend register as its top bits are consumed.
module schoolbook_div #(
    parameter int W  = 233,
    parameter int CW = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2*W-1:0]  a,
    input  logic [W-1:0]    b,
    output logic [2*W-1:0]  q,
    output logic [W-1:0]    r,
    output logic            busy,
    output logic            done,
    output logic            div0
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(2 * W - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2*W-1:0]  d_q, d_d;
    logic [W-1:0]    b_q, b_d;
    logic [W:0]      p_q, p_d;
    logic [W-1:0]    alo_q, alo_d;
    logic [2*W-1:0]  q_q, q_d;
    logic [W-1:0]    r_q, r_d;
    logic            div0_q, div0_d;

    logic [W:0]      t;
    logic            qbit;
    logic [W:0]      p_nxt;
    logic [2*W-1:0]  d_nxt;
    logic            accept;
    logic            last;

    // One iteration of the restoring step; P stays below B so W+1 bits hold T.
    always_comb begin
        t     = {p_q[W-1:0], d_q[2*W-1]};
        qbit  = (t >= {1'b0, b_q});
        p_nxt = qbit ? (t - {1'b0, b_q}) : t;
        d_nxt = {d_q[2*W-2:0], qbit};
    end

    assign accept = start && (state_q != RUN);
    assign last   = (state_q == RUN) && (count_q == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            d_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            alo_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            d_q     <= d_d;
            b_q     <= b_d;
            p_q     <= p_d;
            alo_q   <= alo_d;
            q_q     <= q_d;
            r_q     <= r_d;
            div0_q  <= div0_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        d_d     = d_q;
        b_d     = b_q;
        p_d     = p_q;
        alo_d   = alo_q;
        q_d     = q_q;
        r_d     = r_q;
        div0_d  = div0_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = RUN;
                    count_d = '0;
                    d_d     = a;
                    b_d     = b;
                    p_d     = '0;
                    alo_d   = a[W-1:0];
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                d_d     = d_nxt;
                p_d     = p_nxt;
                count_d = count_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    // Divide by zero overrides whatever the datapath produced.
                    if (b_q == '0) begin
                        q_d    = '1;
                        r_d    = alo_q;
                        div0_d = 1'b1;
                    end else begin
                        q_d    = d_nxt;
                        r_d    = p_nxt[W-1:0];
                        div0_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        q    = q_q;
        r    = r_q;
        div0 = div0_q;
    end

endmodule

// File: tb/tb_schoolbook_div.sv
// Self-checking bench for schoolbook_div; expected results come from native wide / and %.
module tb_schoolbook_div;
    localparam int W   = 233;
    localparam int W2  = 2 * W;
    localparam int LAT = W2;
    localparam int TMO = 2000;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W2-1:0]  a;
    logic [W-1:0]   b;
    logic [W2-1:0]  q;
    logic [W-1:0]   r;
    logic           busy, done, div0;

    int n_checks = 0;
    int n_fail   = 0;

    schoolbook_div #(.W(W), .CW(9)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .q(q), .r(r), .busy(busy), .done(done), .div0(div0)
    );

    always #5 clk = ~clk;

    function automatic logic [W2-1:0] rand_wide();
        logic [W2-1:0] v = '0;
        for (int i = 0; i < 15; i++) v = (v << 32) | W2'($urandom);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one start, then waits for done; optionally scrambles inputs while running.
    task automatic run_div(input logic [W2-1:0] av, input logic [W-1:0] bv, input bit scramble,
                           output int lat, output int bcnt);
        a = av; b = bv; start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < TMO) begin
            if (scramble) begin
                a = rand_wide(); b = W'(rand_wide()); start = 1'b1;
            end
            step();
            lat++;
            if (busy) bcnt++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 100; b = 7;
        step(); step();
        rst = 1'b0; start = 1'b0;
        n_checks++; if (q !== '0)     begin n_fail++; $display("FAIL reset_q got=%h want=0", q); end
        n_checks++; if (r !== '0)     begin n_fail++; $display("FAIL reset_r got=%h want=0", r); end
        n_checks++; if ({busy, done, div0} !== 3'b000)
            begin n_fail++; $display("FAIL reset_flags got=%b want=000", {busy, done, div0}); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored busy=%b want=0", busy); end
    endtask

    task automatic test_basic();
        int lat, bcnt;
        run_div(100, 7, 1'b0, lat, bcnt);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency got=%0d want=%0d", lat, LAT); end
        n_checks++; if (bcnt !== LAT) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d want=%0d", bcnt, LAT); end
        n_checks++; if (q !== W2'(14)) begin n_fail++; $display("FAIL basic_q got=%0d want=14", q); end
        n_checks++; if (r !== W'(2))  begin n_fail++; $display("FAIL basic_r got=%0d want=2", r); end
        n_checks++; if (div0 !== 1'b0) begin n_fail++; $display("FAIL basic_div0 got=%b want=0", div0); end
        step();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    endtask

    task automatic test_patterns();
        int lat, bcnt;
        logic [W2-1:0] av, qe;
        run_div('1, '1, 1'b0, lat, bcnt);
        qe = (W2'(1) << W) + 1;
        n_checks++; if (q !== qe) begin n_fail++; $display("FAIL max_q got=%h want=%h", q, qe); end
        n_checks++; if (r !== '0) begin n_fail++; $display("FAIL max_r got=%h want=0", r); end
        step();
        run_div(5, 9, 1'b0, lat, bcnt);
        n_checks++; if (q !== '0 || r !== W'(5))
            begin n_fail++; $display("FAIL small_q_r got=%0d,%0d want=0,5", q, r); end
        step();
        av = rand_wide();
        run_div(av, 1, 1'b0, lat, bcnt);
        n_checks++; if (q !== av || r !== '0)
            begin n_fail++; $display("FAIL b1_q got=%h r=%h want=%h r=0", q, r, av); end
        step();
        run_div(W2'(16'h1234), '0, 1'b0, lat, bcnt);
        n_checks++; if (div0 !== 1'b1) begin n_fail++; $display("FAIL div0_flag got=%b want=1", div0); end
        n_checks++; if (q !== '1) begin n_fail++; $display("FAIL div0_q got=%h want=all ones", q); end
        n_checks++; if (r !== W'(16'h1234)) begin n_fail++; $display("FAIL div0_r got=%h want=1234", r); end
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL div0_latency got=%0d want=%0d", lat, LAT); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [W2-1:0] a1, a2, q1;
        logic [W-1:0]  b1, b2;
        int lat;
        a1 = rand_wide(); b1 = W'(rand_wide() >> 100) | W'(1);
        a = a1; b = b1; start = 1'b1;
        step();
        lat = 0;
        while (!done && lat < TMO) begin
            a = rand_wide(); b = W'(rand_wide());
            step();
            lat++;
        end
        q1 = a1 / W2'(b1);
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_latency1 got=%0d want=%0d", lat, LAT); end
        n_checks++; if (q !== q1 || r !== W'(a1 % W2'(b1)))
            begin n_fail++; $display("FAIL b2b_result1 got=%h want=%h", q, q1); end
        a2 = rand_wide(); b2 = W'(rand_wide() >> 50) | W'(1);
        a = a2; b = b2;
        step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart busy=%b want=1", busy); end
        n_checks++; if (q !== q1) begin n_fail++; $display("FAIL b2b_hold_q got=%h want=%h", q, q1); end
        lat = 0;
        while (!done && lat < TMO) begin
            a = rand_wide(); b = W'(rand_wide()); start = 1'b0;
            step();
            lat++;
        end
        n_checks++; if (q !== a2 / W2'(b2) || r !== W'(a2 % W2'(b2)))
            begin n_fail++; $display("FAIL b2b_result2 got=%h want=%h", q, a2 / W2'(b2)); end
        start = 1'b0;
        step();
    endtask

    task automatic test_mid_reset();
        int lat, bcnt;
        a = rand_wide(); b = 3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (199) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (q !== '0 || r !== '0 || busy !== 1'b0 || done !== 1'b0)
            begin n_fail++; $display("FAIL midrst_clear q=%h r=%h busy=%b done=%b want all 0", q, r, busy, done); end
        run_div(100, 7, 1'b0, lat, bcnt);
        n_checks++; if (q !== W2'(14) || r !== W'(2))
            begin n_fail++; $display("FAIL midrst_after got=%0d,%0d want=14,2", q, r); end
        step();
    endtask

    task automatic test_regression();
        int lat, bcnt;
        logic [W2-1:0] av, bw, qe;
        logic [W-1:0]  bv;
        for (int i = 0; i < 110; i++) begin
            av = rand_wide() >> $urandom_range(0, W2 - 1);
            bv = W'(rand_wide()) >> $urandom_range(0, W - 1);
            if (bv == '0) bv = 1;
            bw = W2'(bv);
            run_div(av, bv, i[0], lat, bcnt);
            qe = av / bw;
            n_checks++; if (q !== qe || W2'(r) !== av % bw || lat !== LAT)
                begin n_fail++; $display("FAIL regr_%0d a=%h b=%h q=%h r=%h lat=%0d", i, av, bv, q, r, lat); end
            n_checks++; if ((W2 + W)'(q) * (W2 + W)'(bv) + (W2 + W)'(r) !== (W2 + W)'(av) || r >= bv)
                begin n_fail++; $display("FAIL regr_identity_%0d q=%h r=%h", i, q, r); end
            step();
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL regr_done_extra_%0d got=1 want=0", i); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_patterns();
        test_back_to_back();
        test_mid_reset();
        test_regression();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
